apd_oneshot_multi: RTL and testbench

//  Multi-channel successor to the single APD one-shot. Each channel synchronises an

---
 rtl/apd_oneshot_multi.sv | 187 ++++++++++++++++++
 tb/tb_apd_oneshot_multi.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apd_oneshot_multi.sv
// Multi-channel APD one-shot: synchronise, rising-edge detect, fixed-width pulse, then dead time.
// Latency: input high before edge k -> out high after edge k+SYNC_STAGES+1.
// No backpressure: every edge is accepted, or else dropped and counted as rejected.
//
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   in               raw asynchronous detector inputs, one bit per channel
//   enable           per-channel arm; a disarmed idle channel ignores edges and does not count them
//   dead_time        per-channel dead time in cycles, channel i at [i*DT_W +: DT_W]
//   pulse_width      output pulse width in cycles, shared by all channels; 0 behaves as 1
//   clear_counts     synchronous clear of every event counter, wins over a same-cycle increment
//   out              registered one-shot outputs
//   busy             high while a channel is in its pulse or its dead time
//   accepted_count   per-channel saturating count of edges that started a pulse
//   rejected_count   per-channel saturating count of edges seen during pulse or dead time

module apd_oneshot_multi #(
    parameter int N_CH        = 4,
    parameter int DT_W        = 8,
    parameter int PW_W        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_CH-1:0]        in,
    input  logic [N_CH-1:0]        enable,
    input  logic [N_CH*DT_W-1:0]   dead_time,
    input  logic [PW_W-1:0]        pulse_width,
    input  logic                   clear_counts,
    output logic [N_CH-1:0]        out,
    output logic [N_CH-1:0]        busy,
    output logic [N_CH*CNT_W-1:0]  accepted_count,
    output logic [N_CH*CNT_W-1:0]  rejected_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    localparam logic [PW_W-1:0]  PW_ONE  = PW_W'(1);
    localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A zero pulse width would otherwise underflow the pulse counter; it
    // behaves as the shortest legal pulse instead.
    logic [PW_W-1:0] pw_eff;
    assign pw_eff = (pulse_width == '0) ? PW_ONE : pulse_width;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch

        // ---------------------------------------------------------------
        // Input synchroniser and edge detector.
        // rise_q is registered so the FSM sees a clean single-cycle strobe;
        // this extra stage sets the SYNC_STAGES+1 cycle input-to-output latency.
        // ---------------------------------------------------------------
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   rise_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= '0;
                prev_q <= 1'b0;
                rise_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], in[i]};
                prev_q <= sync_q[SYNC_STAGES-1];
                rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            end
        end

        // ---------------------------------------------------------------
        // One-shot FSM
        // ---------------------------------------------------------------
        state_t          state_q, state_d;
        logic [PW_W-1:0] pcnt_q,  pcnt_d;
        logic [DT_W-1:0] dcnt_q,  dcnt_d;
        logic [DT_W-1:0] dt_q,    dt_d;
        logic            out_q,   out_d;
        logic            busy_q;
        logic            acc_inc;
        logic            rej_inc;

        always_comb begin
            state_d = state_q;
            pcnt_d  = pcnt_q;
            dcnt_d  = dcnt_q;
            dt_d    = dt_q;
            out_d   = out_q;
            acc_inc = 1'b0;
            rej_inc = 1'b0;

            unique case (state_q)
                IDLE: begin
                    // Dead time is latched here, so later changes on the
                    // dead_time bus only affect the next accepted edge.
                    if (rise_q && enable[i]) begin
                        out_d   = 1'b1;
                        dt_d    = dead_time[i*DT_W +: DT_W];
                        pcnt_d  = pw_eff - PW_ONE;
                        acc_inc = 1'b1;
                        state_d = PULSE;
                    end
                end
                PULSE: begin
                    // Edges here are dropped whatever enable says.
                    rej_inc = rise_q;
                    if (pcnt_q == '0) begin
                        out_d = 1'b0;
                        if (dt_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            dcnt_d  = dt_q - DT_ONE;
                            state_d = DEAD;
                        end
                    end else begin
                        pcnt_d = pcnt_q - PW_ONE;
                    end
                end
                DEAD: begin
                    rej_inc = rise_q;
                    if (dcnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        dcnt_d = dcnt_q - DT_ONE;
                    end
                end
                default: begin
                    out_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= IDLE;
                pcnt_q  <= '0;
                dcnt_q  <= '0;
                dt_q    <= '0;
                out_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                pcnt_q  <= pcnt_d;
                dcnt_q  <= dcnt_d;
                dt_q    <= dt_d;
                out_q   <= out_d;
                // Registered alongside the state so busy is glitch-free.
                busy_q  <= (state_d != IDLE);
            end
        end

        // ---------------------------------------------------------------
        // Saturating event counters; clear wins over an increment.
        // ---------------------------------------------------------------
        logic [CNT_W-1:0] acc_q;
        logic [CNT_W-1:0] rej_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                acc_q <= '0;
                rej_q <= '0;
            end else if (clear_counts) begin
                acc_q <= '0;
                rej_q <= '0;
            end else begin
                if (acc_inc && (acc_q != CNT_MAX)) begin
                    acc_q <= acc_q + CNT_ONE;
                end
                if (rej_inc && (rej_q != CNT_MAX)) begin
                    rej_q <= rej_q + CNT_ONE;
                end
            end
        end

        assign out[i]                            = out_q;
        assign busy[i]                           = busy_q;
        assign accepted_count[i*CNT_W +: CNT_W]  = acc_q;
        assign rejected_count[i*CNT_W +: CNT_W]  = rej_q;
    end

endmodule

// File: tb/tb_apd_oneshot_multi.sv
// Bench for apd_oneshot_multi: a reference model built on accept timestamps and
// ready times checks every output each cycle, while directed tables and sequences
// cover the timing corners. A second instance with 4-bit counters shares the stimulus.

module tb_apd_oneshot_multi;

    localparam int N_CH = 4;
    localparam int DT_W = 8;
    localparam int PW_W = 4;
    localparam int SYNC = 2;
    localparam int CW   = 16;
    localparam int CW4  = 4;
    localparam int MAXC = 8192;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic [N_CH-1:0]       in;
    logic [N_CH-1:0]       enable;
    logic [N_CH*DT_W-1:0]  dead_time;
    logic [PW_W-1:0]       pulse_width;
    logic                  clear_counts;
    logic [N_CH-1:0]       out,  busy;
    logic [N_CH-1:0]       out4, busy4;
    logic [N_CH*CW-1:0]    acc16, rej16;
    logic [N_CH*CW4-1:0]   acc4,  rej4;

    always #5 clock = ~clock;

    apd_oneshot_multi #(.N_CH(N_CH), .DT_W(DT_W), .PW_W(PW_W), .SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .in(in), .enable(enable), .dead_time(dead_time),
        .pulse_width(pulse_width), .clear_counts(clear_counts), .out(out), .busy(busy),
        .accepted_count(acc16), .rejected_count(rej16)
    );

    apd_oneshot_multi #(.N_CH(N_CH), .DT_W(DT_W), .PW_W(PW_W), .SYNC_STAGES(SYNC), .CNT_W(CW4)) dut4 (
        .clock(clock), .reset_n(reset_n), .in(in), .enable(enable), .dead_time(dead_time),
        .pulse_width(pulse_width), .clear_counts(clear_counts), .out(out4), .busy(busy4),
        .accepted_count(acc4), .rejected_count(rej4)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: per channel, remember when the last pulse was
    // accepted, how long it lasts, and the first cycle a new edge may win.
    // ------------------------------------------------------------------
    logic [N_CH-1:0]      h_in  [0:MAXC-1];
    logic [N_CH-1:0]      h_en  [0:MAXC-1];
    logic [N_CH*DT_W-1:0] h_dt  [0:MAXC-1];
    logic [PW_W-1:0]      h_pw  [0:MAXC-1];
    logic                 h_clr [0:MAXC-1];
    int cyc      = 0;
    int last_rst = 0;
    int acc_t [N_CH];
    int pwl   [N_CH];
    int dtl   [N_CH];
    int ready [N_CH];
    int n_acc [N_CH];
    int n_rej [N_CH];

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            acc_t[c] = -1000; pwl[c] = 0; dtl[c] = 0; ready[c] = 0;
            n_acc[c] = 0; n_rej[c] = 0;
        end
    endfunction

    // Input sample taken at edge k, or 0 if a reset wiped it out.
    function automatic bit v_eff(int k, int c);
        if (k < 1 || k <= last_rst) return 1'b0;
        return h_in[k][c];
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    // A 0->1 step sampled at edge e-SYNC-1 reaches the channel logic at edge e.
    function automatic void model_edge(int e);
        for (int c = 0; c < N_CH; c++) begin
            if (v_eff(e-SYNC-1, c) && !v_eff(e-SYNC-2, c)) begin
                if (e < ready[c]) begin
                    n_rej[c]++;
                end else if (h_en[e][c]) begin
                    acc_t[c] = e;
                    pwl[c]   = (h_pw[e] == 0) ? 1 : int'(h_pw[e]);
                    dtl[c]   = int'(h_dt[e][c*DT_W +: DT_W]);
                    ready[c] = e + pwl[c] + dtl[c] + 1;
                    n_acc[c]++;
                end
            end
            if (h_clr[e]) begin
                n_acc[c] = 0;
                n_rej[c] = 0;
            end
        end
    endfunction

    task automatic check_outputs();
        for (int c = 0; c < N_CH; c++) begin
            bit eo, eb;
            eo = (cyc >= acc_t[c]) && (cyc < acc_t[c] + pwl[c]);
            eb = (cyc >= acc_t[c]) && (cyc < acc_t[c] + pwl[c] + dtl[c]);
            chk($sformatf("out[%0d]@%0d", c, cyc),   out[c],  eo);
            chk($sformatf("busy[%0d]@%0d", c, cyc),  busy[c], eb);
            chk($sformatf("out4[%0d]@%0d", c, cyc),  out4[c], eo);
            chk($sformatf("acc[%0d]@%0d", c, cyc),   acc16[c*CW +: CW],  sat(n_acc[c], 65535));
            chk($sformatf("rej[%0d]@%0d", c, cyc),   rej16[c*CW +: CW],  sat(n_rej[c], 65535));
            chk($sformatf("acc4[%0d]@%0d", c, cyc),  acc4[c*CW4 +: CW4], sat(n_acc[c], 15));
            chk($sformatf("rej4[%0d]@%0d", c, cyc),  rej4[c*CW4 +: CW4], sat(n_rej[c], 15));
        end
    endtask

    always @(negedge reset_n) begin
        last_rst = cyc;
        model_reset();
    end

    initial begin : monitor
        forever begin
            @(posedge clock);
            cyc++;
            if (cyc >= MAXC) begin
                $display("FAIL cycle_budget: reached %0d cycles, limit %0d", cyc, MAXC);
                $fatal(1, "cycle budget exhausted");
            end
            h_in[cyc]  = in;
            h_en[cyc]  = enable;
            h_dt[cyc]  = dead_time;
            h_pw[cyc]  = pulse_width;
            h_clr[cyc] = clear_counts;
            if (!reset_n) last_rst = cyc;
            else          model_edge(cyc);
            #1;
            check_outputs();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus (driven on the falling edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic int acc_of(int c);
        return int'(acc16[c*CW +: CW]);
    endfunction

    function automatic int rej_of(int c);
        return int'(rej16[c*CW +: CW]);
    endfunction

    typedef struct {
        int pw;
        int dt;
        int exp_lat;
        int exp_hi;
        int exp_busy;
    } vec_t;

    vec_t vecs [6];

    initial begin : stim
        int a0, r0, lat, hi, bsy;

        vecs[0] = '{pw: 3,  dt: 5,   exp_lat: 4, exp_hi: 3,  exp_busy: 8};
        vecs[1] = '{pw: 0,  dt: 0,   exp_lat: 4, exp_hi: 1,  exp_busy: 1};
        vecs[2] = '{pw: 1,  dt: 3,   exp_lat: 4, exp_hi: 1,  exp_busy: 4};
        vecs[3] = '{pw: 15, dt: 0,   exp_lat: 4, exp_hi: 15, exp_busy: 15};
        vecs[4] = '{pw: 7,  dt: 255, exp_lat: 4, exp_hi: 7,  exp_busy: 262};
        vecs[5] = '{pw: 2,  dt: 1,   exp_lat: 4, exp_hi: 2,  exp_busy: 3};

        model_reset();
        reset_n      = 1'b0;
        in           = '1;
        enable       = '1;
        dead_time    = '0;
        pulse_width  = '0;
        clear_counts = 1'b0;

        // Inputs high across reset release: one pulse each, SYNC+1 edges later.
        tick(3);
        chk("reset_out", out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_acc", acc16, 0);
        reset_n = 1'b1;
        tick(3);
        chk("release_early_out", out, 0);
        tick(1);
        chk("release_out", out, 4'hF);
        for (int c = 0; c < N_CH; c++) chk($sformatf("release_acc[%0d]", c), acc_of(c), 1);
        tick(3);
        in = '0;
        tick(5);

        // Single-edge table on channel 0.
        for (int v = 0; v < 6; v++) begin
            pulse_width     = PW_W'(vecs[v].pw);
            dead_time[7:0]  = 8'(vecs[v].dt);
            tick(2);
            in[0] = 1'b1;
            lat = 0;
            while (!out[0] && lat < 20) begin
                tick(1);
                lat++;
            end
            chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            hi = 0; bsy = 0;
            while (busy[0] && bsy < 400) begin
                if (out[0]) hi++;
                bsy++;
                tick(1);
            end
            chk($sformatf("vec%0d_out_cycles", v), hi, vecs[v].exp_hi);
            chk($sformatf("vec%0d_busy_cycles", v), bsy, vecs[v].exp_busy);
            in[0] = 1'b0;
            tick(4);
        end

        // Re-trigger 8 cycles after the first edge is dropped; 9 is accepted.
        pulse_width    = 4'd3;
        dead_time[7:0] = 8'd5;
        for (int gap = 8; gap <= 9; gap++) begin
            a0 = acc_of(0); r0 = rej_of(0);
            in[0] = 1'b1; tick(1);
            in[0] = 1'b0; tick(gap - 1);
            in[0] = 1'b1; tick(1);
            in[0] = 1'b0; tick(20);
            chk($sformatf("gap%0d_acc", gap), acc_of(0) - a0, (gap == 8) ? 1 : 2);
            chk($sformatf("gap%0d_rej", gap), rej_of(0) - r0, (gap == 8) ? 1 : 0);
        end

        // Channel 1: dead time 10, edges every 4 cycles for 40 cycles.
        pulse_width     = 4'd1;
        dead_time[15:8] = 8'd10;
        a0 = acc_of(1); r0 = rej_of(1);
        for (int k = 0; k < 10; k++) begin
            in[1] = 1'b1; tick(2);
            in[1] = 1'b0; tick(2);
        end
        tick(15);
        chk("ch1_acc", acc_of(1) - a0, 4);
        chk("ch1_rej", rej_of(1) - r0, 6);
        chk("ch1_total", (acc_of(1) - a0) + (rej_of(1) - r0), 10);

        // Channel 2: zero width and zero dead time, an edge every 2 cycles.
        pulse_width      = 4'd0;
        dead_time[23:16] = 8'd0;
        a0 = acc_of(2); r0 = rej_of(2);
        for (int k = 0; k < 10; k++) begin
            in[2] = 1'b1; tick(1);
            in[2] = 1'b0; tick(1);
        end
        tick(6);
        chk("ch2_acc", acc_of(2) - a0, 10);
        chk("ch2_rej", rej_of(2) - r0, 0);

        // Channel 3: saturation in the 4-bit build, then clear against an edge.
        dead_time[31:24] = 8'd0;
        clear_counts = 1'b1; tick(1); clear_counts = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in[3] = 1'b1; tick(1);
            in[3] = 1'b0; tick(1);
        end
        tick(6);
        chk("sat_acc16", acc_of(3), 20);
        chk("sat_acc4", acc4[3*CW4 +: CW4], 15);
        in[3] = 1'b1; tick(1);
        in[3] = 1'b0; tick(2);
        clear_counts = 1'b1; tick(1);
        clear_counts = 1'b0;
        chk("clear_acc16", acc_of(3), 0);
        chk("clear_acc4", acc4[3*CW4 +: CW4], 0);
        chk("clear_pulse_still_fires", out[3], 1);
        tick(4);

        // Channel 2: reset in the middle of its dead time.
        pulse_width      = 4'd2;
        dead_time[23:16] = 8'd20;
        in[2] = 1'b1;
        tick(8);
        chk("dead_busy_before", busy[2], 1);
        chk("dead_out_before", out[2], 0);
        reset_n = 1'b0;
        #1;
        chk("dead_rst_busy", busy[2], 0);
        chk("dead_rst_out", out[2], 0);
        chk("dead_rst_acc", acc_of(2), 0);
        in[2] = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        in[2] = 1'b1;
        tick(4);
        chk("after_rst_out", out[2], 1);
        chk("after_rst_acc", acc_of(2), 1);
        in[2] = 1'b0;
        tick(30);

        // Randomised traffic, checked cycle by cycle by the model.
        for (int k = 0; k < 2500; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(2) == 0) in[c] = ~in[c];
            end
            if ($urandom_range(60) == 0) enable = 4'($urandom_range(15) | $urandom_range(15));
            if ($urandom_range(40) == 0) begin
                for (int c = 0; c < N_CH; c++) dead_time[c*DT_W +: DT_W] = 8'($urandom_range(12));
            end
            if ($urandom_range(40) == 0) pulse_width = 4'($urandom_range(5));
            clear_counts = ($urandom_range(99) == 0);
            if (k == 1200) reset_n = 1'b0;
            if (k == 1203) reset_n = 1'b1;
            tick(1);
        end
        clear_counts = 1'b0;
        in = '0;
        tick(40);
        chk("final_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "time limit");
    end

endmodule
